// File: rtl/stack_round_sequencer.sv
// Stacker game sequencer: slider motion on a step tick, drop/trim of rows, win/lose.
// Build option SPEED_RAMP_EN: step period shrinks by TICK_DEC per row, floored at TICK_MIN.
module stack_round_sequencer #(
  parameter int X_MIN      = 144,
  parameter int X_MAX      = 784,
  parameter int STEP       = 10,
  parameter int ROWS       = 10,
  parameter int INIT_WIDTH = 40,
  parameter int MIN_WIDTH  = 10,
  parameter int TICK_BASE  = 2500000,
  parameter int TICK_DEC   = 200000,
  parameter int TICK_MIN   = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       drop,
  input  logic [3:0] row_rd_idx,
  output logic [9:0] row_rd_left,
  output logic [9:0] row_rd_right,
  output logic       row_rd_valid,
  output logic [9:0] cur_left,
  output logic [9:0] cur_right,
  output logic [3:0] cur_row,
  output logic       step_pulse,
  output logic [2:0] state_o,
  output logic       win,
  output logic       lose
);
  localparam int XW = 10;
  localparam int RW = 4;
  localparam logic [XW-1:0] XMIN_V   = XW'(X_MIN);
  localparam logic [XW:0]   XMAX_V   = (XW+1)'(X_MAX);
  localparam logic [XW-1:0] STEP_V   = XW'(STEP);
  localparam logic [XW-1:0] INIT_R_V = XW'(X_MIN + INIT_WIDTH);
  localparam logic [XW-1:0] MIN_W_V  = XW'(MIN_WIDTH);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam int PMAX = (TICK_BASE > TICK_MIN) ? TICK_BASE : TICK_MIN;
  localparam int CW   = $clog2(PMAX + 1);
`ifdef SPEED_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MOVE    = 3'd1,
    S_TRIM    = 3'd2,
    S_ADVANCE = 3'd3,
    S_WIN     = 3'd4,
    S_LOSE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] cur_left_q, cur_left_d, cur_right_q, cur_right_d;
  logic [RW-1:0] cur_row_q, cur_row_d;
  logic          dir_right_q, dir_right_d;
  logic [CW-1:0] tick_q, tick_d;
  logic          step_pulse_q, step_pulse_d;

  logic          row_wr, row_clr;
  logic [RW-1:0] row_wr_idx;
  logic [XW-1:0] row_wr_left, row_wr_right;
  logic [XW-1:0] row_left  [ROWS];
  logic [XW-1:0] row_right [ROWS];
  logic [ROWS-1:0] row_valid;

  logic [XW-1:0] prev_left, prev_right, trim_left, trim_right;
  logic          trim_ok;
  logic [31:0]   dec_full, period_full;
  logic          tick_last;

  // Per-row extent storage; each row owns its own write decode.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [XW-1:0] left_q, left_d, right_q, right_d;
    logic          valid_q, valid_d;

    always_comb begin
      left_d  = left_q;
      right_d = right_q;
      valid_d = valid_q;
      if (row_clr) begin
        valid_d = 1'b0;
      end else if (row_wr && row_wr_idx == RW'(gi)) begin
        left_d  = row_wr_left;
        right_d = row_wr_right;
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        left_q  <= '0;
        right_q <= '0;
        valid_q <= 1'b0;
      end else begin
        left_q  <= left_d;
        right_q <= right_d;
        valid_q <= valid_d;
      end
    end

    assign row_left[gi]  = left_q;
    assign row_right[gi] = right_q;
    assign row_valid[gi] = valid_q;
  end

  // Row below the active one for trimming, plus the renderer read port.
  always_comb begin
    prev_left    = '0;
    prev_right   = '0;
    row_rd_left  = '0;
    row_rd_right = '0;
    row_rd_valid = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      if (RW'(i) == cur_row_q - RW'(1)) begin
        prev_left  = row_left[i];
        prev_right = row_right[i];
      end
      if (RW'(i) == row_rd_idx && row_valid[i]) begin
        row_rd_left  = row_left[i];
        row_rd_right = row_right[i];
        row_rd_valid = 1'b1;
      end
    end
  end

  always_comb begin
    trim_left  = (cur_left_q > prev_left) ? cur_left_q : prev_left;
    trim_right = (cur_right_q < prev_right) ? cur_right_q : prev_right;
    trim_ok    = 1'b0;
    if (trim_right > trim_left) begin
      trim_ok = ((trim_right - trim_left) >= MIN_W_V);
    end
  end

  // Step period; the comparison form avoids underflow when the decrement exceeds the base.
  always_comb begin
    dec_full = RAMP ? (32'(cur_row_q) * 32'(TICK_DEC)) : 32'd0;
    if (!RAMP) begin
      period_full = 32'(TICK_BASE);
    end else if (32'(TICK_BASE) <= 32'(TICK_MIN) + dec_full) begin
      period_full = 32'(TICK_MIN);
    end else begin
      period_full = 32'(TICK_BASE) - dec_full;
    end
    tick_last = (tick_q == CW'(period_full - 32'd1));
  end

  always_comb begin
    state_d      = state_q;
    cur_left_d   = cur_left_q;
    cur_right_d  = cur_right_q;
    cur_row_d    = cur_row_q;
    dir_right_d  = dir_right_q;
    tick_d       = tick_q;
    step_pulse_d = 1'b0;
    row_wr       = 1'b0;
    row_clr      = 1'b0;
    row_wr_idx   = cur_row_q;
    row_wr_left  = cur_left_q;
    row_wr_right = cur_right_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MOVE;
          tick_d  = '0;
        end
      end
      S_MOVE: begin
        if (drop) begin
          tick_d = '0;
          if (cur_row_q == '0) begin
            row_wr  = 1'b1;
            state_d = S_ADVANCE;
          end else begin
            state_d = S_TRIM;
          end
        end else if (tick_last) begin
          tick_d       = '0;
          step_pulse_d = 1'b1;
          if (dir_right_q) begin
            if ({1'b0, cur_right_q} + {1'b0, STEP_V} > XMAX_V) begin
              dir_right_d = 1'b0;
              cur_left_d  = cur_left_q - STEP_V;
              cur_right_d = cur_right_q - STEP_V;
            end else begin
              cur_left_d  = cur_left_q + STEP_V;
              cur_right_d = cur_right_q + STEP_V;
            end
          end else begin
            if ({1'b0, cur_left_q} < {1'b0, XMIN_V} + {1'b0, STEP_V}) begin
              dir_right_d = 1'b1;
              cur_left_d  = cur_left_q + STEP_V;
              cur_right_d = cur_right_q + STEP_V;
            end else begin
              cur_left_d  = cur_left_q - STEP_V;
              cur_right_d = cur_right_q - STEP_V;
            end
          end
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
      S_TRIM: begin
        if (trim_ok) begin
          row_wr       = 1'b1;
          row_wr_left  = trim_left;
          row_wr_right = trim_right;
          cur_left_d   = trim_left;
          cur_right_d  = trim_right;
          state_d      = S_ADVANCE;
        end else begin
          state_d = S_LOSE;
        end
      end
      S_ADVANCE: begin
        if (cur_row_q == LAST_ROW) begin
          state_d = S_WIN;
        end else begin
          cur_row_d   = cur_row_q + RW'(1);
          cur_left_d  = XMIN_V;
          cur_right_d = XMIN_V + (cur_right_q - cur_left_q);
          dir_right_d = 1'b1;
          tick_d      = '0;
          state_d     = S_MOVE;
        end
      end
      S_WIN, S_LOSE: begin
        if (start) begin
          row_clr     = 1'b1;
          cur_left_d  = XMIN_V;
          cur_right_d = INIT_R_V;
          cur_row_d   = '0;
          dir_right_d = 1'b1;
          tick_d      = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_left_q   <= XMIN_V;
      cur_right_q  <= INIT_R_V;
      cur_row_q    <= '0;
      dir_right_q  <= 1'b1;
      tick_q       <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_left_q   <= cur_left_d;
      cur_right_q  <= cur_right_d;
      cur_row_q    <= cur_row_d;
      dir_right_q  <= dir_right_d;
      tick_q       <= tick_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign cur_left   = cur_left_q;
  assign cur_right  = cur_right_q;
  assign cur_row    = cur_row_q;
  assign step_pulse = step_pulse_q;
  assign state_o    = state_q;
  assign win        = (state_q == S_WIN);
  assign lose       = (state_q == S_LOSE);
endmodule

// File: tb/tb_stack_round_sequencer.sv
// Scoreboard bench for stack_round_sequencer: expected slider steps and state
// transitions are queued by the stimulus and popped by a negedge monitor.
module tb_stack_round_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       drop = 1'b0;
  logic [3:0] row_rd_idx = 4'd0;
  logic [9:0] row_rd_left, row_rd_right, cur_left, cur_right;
  logic       row_rd_valid, step_pulse, win, lose;
  logic [3:0] cur_row;
  logic [2:0] state_o;

`ifdef SPEED_RAMP_EN
  localparam int P1 = 3;
  localparam int P2 = 2;
`else
  localparam int P1 = 4;
  localparam int P2 = 4;
`endif

  stack_round_sequencer #(
    .X_MIN(144), .X_MAX(204), .STEP(10), .ROWS(3), .INIT_WIDTH(40),
    .MIN_WIDTH(10), .TICK_BASE(4), .TICK_DEC(1), .TICK_MIN(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .drop(drop),
    .row_rd_idx(row_rd_idx), .row_rd_left(row_rd_left), .row_rd_right(row_rd_right),
    .row_rd_valid(row_rd_valid), .cur_left(cur_left), .cur_right(cur_right),
    .cur_row(cur_row), .step_pulse(step_pulse), .state_o(state_o),
    .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {int left; int right; int at;} step_t;
  step_t step_q[$];
  int    state_q[$];
  step_t exp_step;
  int    exp_state;
  logic [2:0] prev_state = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] idx, input int v, input int l, input int r);
    row_rd_idx = idx;
    #1;
    chk({tag, "_valid"}, {31'd0, row_rd_valid}, v);
    chk({tag, "_left"}, {22'd0, row_rd_left}, l);
    chk({tag, "_right"}, {22'd0, row_rd_right}, r);
  endtask

  // Returns #1 after the posedge that makes cyc == c.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_step(input int l, input int r, input int at);
    step_t s;
    s.left = l; s.right = r; s.at = at;
    step_q.push_back(s);
  endtask

  // Monitor: every step_pulse and every state change must match the next queued expectation.
  always @(negedge clk) begin
    if (step_pulse === 1'b1) begin
      n_vec++;
      if (step_q.size() == 0) begin
        n_err++;
        $display("FAIL step: unexpected step_pulse at cycle %0d (left %0d right %0d)", cyc, cur_left, cur_right);
      end else begin
        exp_step = step_q.pop_front();
        if (cur_left !== 10'(exp_step.left) || cur_right !== 10'(exp_step.right) || cyc != exp_step.at) begin
          n_err++;
          $display("FAIL step: got %0d/%0d at cycle %0d required %0d/%0d at cycle %0d",
                   cur_left, cur_right, cyc, exp_step.left, exp_step.right, exp_step.at);
        end else begin
          $display("ok   step -> %0d/%0d at cycle %0d", cur_left, cur_right, cyc);
        end
      end
    end
    if (state_o !== prev_state) begin
      n_vec++;
      if (state_q.size() == 0) begin
        n_err++;
        $display("FAIL state: unexpected change %0d -> %0d at cycle %0d", prev_state, state_o, cyc);
      end else begin
        exp_state = state_q.pop_front();
        if (state_o !== 3'(exp_state)) begin
          n_err++;
          $display("FAIL state: got %0d required %0d at cycle %0d", state_o, exp_state, cyc);
        end else begin
          $display("ok   state -> %0d at cycle %0d", state_o, cyc);
        end
      end
      prev_state = state_o;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  int k, d, e;

  initial begin
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_state", {29'd0, state_o}, 0);
    chk("rst_left", {22'd0, cur_left}, 144);
    chk("rst_right", {22'd0, cur_right}, 184);
    chk("rst_row", {28'd0, cur_row}, 0);
    chk("rst_flags", {29'd0, step_pulse, win, lose}, 0);
    rd_chk("rst_row0", 4'd0, 0, 0, 0);

    // Game A: free running with bounces, then a drop on a terminal tick, then async reset.
    wait_until(cyc + 2);
    k = cyc;
    start = 1'b1;
    state_q.push_back(1);
    push_step(154, 194, k + 5);
    push_step(164, 204, k + 9);
    push_step(154, 194, k + 13);
    push_step(144, 184, k + 17);
    push_step(154, 194, k + 21);
    wait_until(k + 1);
    start = 1'b0;
    wait_until(k + 24);
    drop = 1'b1;
    state_q.push_back(3);
    state_q.push_back(1);
    wait_until(k + 25);
    drop = 1'b0;
    chk("A_drop_tick_left", {22'd0, cur_left}, 154);
    chk("A_drop_tick_step", {31'd0, step_pulse}, 0);
    rd_chk("A_row0", 4'd0, 1, 154, 194);
    wait_until(k + 26);
    chk("A_row1_idx", {28'd0, cur_row}, 1);
    chk("A_row1_left", {22'd0, cur_left}, 144);
    chk("A_row1_right", {22'd0, cur_right}, 184);
    wait_until(k + 27);
    state_q.push_back(0);
    #2 rst = 1'b1;
    #1;
    chk("A_arst_state", {29'd0, state_o}, 0);
    chk("A_arst_row", {28'd0, cur_row}, 0);
    chk("A_arst_right", {22'd0, cur_right}, 184);
    chk("A_arst_valid0", {31'd0, row_rd_valid}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Game B: aligned drop, trim to 20 px, exact 10 px overlap on the last row -> WIN.
    wait_until(cyc + 2);
    k = cyc;
    start = 1'b1;
    foreach (state_q[i]) chk("B_state_q_drained", 1, 0);
    state_q.push_back(1); state_q.push_back(3); state_q.push_back(1);
    state_q.push_back(2); state_q.push_back(3); state_q.push_back(1);
    state_q.push_back(2); state_q.push_back(3); state_q.push_back(4);
    push_step(154, 194, k + 3 + P1);
    push_step(164, 204, k + 3 + 2 * P1);
    wait_until(k + 1);
    start = 1'b0;
    drop = 1'b1;
    wait_until(k + 2);
    drop = 1'b0;
    rd_chk("B_row0", 4'd0, 1, 144, 184);
    d = k + 3 + 2 * P1;
    wait_until(d);
    drop = 1'b1;
    e = d + 3 + P2;
    push_step(154, 174, e);
    wait_until(d + 1);
    drop = 1'b0;
    rd_chk("B_row1_early", 4'd1, 0, 0, 0);
    wait_until(d + 2);
    rd_chk("B_row1", 4'd1, 1, 164, 184);
    wait_until(d + 3);
    chk("B_row2_idx", {28'd0, cur_row}, 2);
    chk("B_row2_left", {22'd0, cur_left}, 144);
    chk("B_row2_right", {22'd0, cur_right}, 164);
    wait_until(e);
    drop = 1'b1;
    wait_until(e + 1);
    drop = 1'b0;
    wait_until(e + 2);
    rd_chk("B_row2", 4'd2, 1, 164, 174);
    chk("B_win_early", {31'd0, win}, 0);
    wait_until(e + 3);
    chk("B_win", {31'd0, win}, 1);
    chk("B_lose", {31'd0, lose}, 0);
    wait_until(e + 4);
    drop = 1'b1;
    wait_until(e + 5);
    drop = 1'b0;
    wait_until(e + 6);
    chk("B_win_hold_state", {29'd0, state_o}, 4);
    chk("B_win_frozen_left", {22'd0, cur_left}, 164);
    rd_chk("B_row3_oob", 4'd3, 0, 0, 0);
    rd_chk("B_row0_kept", 4'd0, 1, 144, 184);
    wait_until(e + 7);
    start = 1'b1;
    state_q.push_back(0);
    wait_until(e + 8);
    start = 1'b0;
    rd_chk("B_clr_row0", 4'd0, 0, 0, 0);
    rd_chk("B_clr_row1", 4'd1, 0, 0, 0);
    rd_chk("B_clr_row2", 4'd2, 0, 0, 0);
    wait_until(e + 9);
    chk("B_idle_left", {22'd0, cur_left}, 144);
    chk("B_idle_right", {22'd0, cur_right}, 184);
    chk("B_idle_row", {28'd0, cur_row}, 0);
    chk("B_idle_win", {31'd0, win}, 0);

    // Game C: trimmed 20 px row, next slider has zero overlap -> LOSE.
    wait_until(cyc + 2);
    k = cyc;
    start = 1'b1;
    state_q.push_back(1); state_q.push_back(3); state_q.push_back(1);
    state_q.push_back(2); state_q.push_back(3); state_q.push_back(1);
    state_q.push_back(2); state_q.push_back(5);
    push_step(154, 194, k + 3 + P1);
    push_step(164, 204, k + 3 + 2 * P1);
    wait_until(k + 1);
    start = 1'b0;
    drop = 1'b1;
    wait_until(k + 2);
    drop = 1'b0;
    d = k + 3 + 2 * P1;
    wait_until(d);
    drop = 1'b1;
    wait_until(d + 1);
    drop = 1'b0;
    wait_until(d + 3);
    drop = 1'b1;
    wait_until(d + 4);
    drop = 1'b0;
    chk("C_trim_state", {29'd0, state_o}, 2);
    wait_until(d + 5);
    chk("C_lose", {31'd0, lose}, 1);
    chk("C_win", {31'd0, win}, 0);
    rd_chk("C_row2_unwritten", 4'd2, 0, 0, 0);
    rd_chk("C_row1_kept", 4'd1, 1, 164, 184);
    wait_until(d + 6);
    start = 1'b1;
    state_q.push_back(0);
    wait_until(d + 7);
    start = 1'b0;
    chk("C_idle_lose", {31'd0, lose}, 0);
    rd_chk("C_clr_row1", 4'd1, 0, 0, 0);
    rd_chk("C_clr_row0", 4'd0, 0, 0, 0);
    wait_until(d + 12);
    chk("C_stay_idle", {29'd0, state_o}, 0);
    chk("C_idle_left", {22'd0, cur_left}, 144);

    wait_until(cyc + 3);
    chk("pending_steps", step_q.size(), 0);
    chk("pending_states", state_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
